fifo_ctrl_gen: RTL and testbench

Parametrised FIFO control unit: the successor to our fixed-depth FIFO controller. It owns the read/write pointers and occupancy count for a dual-port RAM with 2**ADDR_W entries, and uses every entry. It produces full/empty plus programmable almost-full/almost-empty flags, accepts a simultaneous read and write in one cycle, and adds a synchronous flush and sticky overflow/underflow error flags. The block sits between the user-facing read/write requests and the RAM. The RAM's asynchronous read port at read_addr drives front_value.

---
 rtl/fifo_ctrl_gen_if.sv | 39 +++
 rtl/fifo_ctrl_gen.sv | 110 +++++++++++
 tb/tb_fifo_ctrl_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_gen_if.sv
// Request/status bundle between the FIFO user, the RAM and fifo_ctrl_gen.
// The slave side is the controller; the master side is its environment.
interface fifo_ctrl_gen_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic              flush;
    logic              clear_err;
    logic [DATA_W-1:0] front_value;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [DATA_W-1:0] read_value;
    logic              read_valid;
    logic              overflow;
    logic              underflow;

    modport slave (
        input  read, write, flush, clear_err, front_value,
        output wr_en, rd_en, read_addr, write_addr, count,
        output empty, full, almost_empty, almost_full,
        output read_value, read_valid, overflow, underflow
    );

    modport master (
        output read, write, flush, clear_err, front_value,
        input  wr_en, rd_en, read_addr, write_addr, count,
        input  empty, full, almost_empty, almost_full,
        input  read_value, read_valid, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_gen.sv
// FIFO pointer/occupancy controller for a 2**ADDR_W-entry dual-port RAM,
// with almost flags, same-cycle read+write, flush and sticky error flags.
module fifo_ctrl_gen #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 8,
    parameter int                AFULL_TH    = (1 << ADDR_W) - 2,
    parameter int                AEMPTY_TH   = 2,
    parameter logic [DATA_W-1:0] EMPTY_VALUE = '0
) (
    input logic            clk,
    input logic            reset,
    fifo_ctrl_gen_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_LIM = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LIM = AEMPTY_TH[ADDR_W:0];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] read_value_q, read_value_d;
    logic              read_valid_q, read_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty, full, rd_en, wr_en;
    logic underflow_ev, overflow_ev;

    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DEPTH);
        rd_en        = bus.read & ~empty & ~bus.flush;
        wr_en        = bus.write & (~full | rd_en) & ~bus.flush;
        underflow_ev = bus.read & empty & ~bus.flush;
        overflow_ev  = bus.write & full & ~rd_en & ~bus.flush;
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        read_value_d = read_value_q;
        read_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (rd_en) begin
            read_value_d = bus.front_value;
            read_valid_d = 1'b1;
        end else if (underflow_ev) begin
            read_value_d = EMPTY_VALUE;
        end

        // Clear first so an error in the same cycle keeps the flag set.
        if (bus.clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (overflow_ev)  overflow_d  = 1'b1;
        if (underflow_ev) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            read_value_q <= EMPTY_VALUE;
            read_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            read_value_q <= read_value_d;
            read_valid_q <= read_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.rd_en        = rd_en;
    assign bus.wr_en        = wr_en;
    assign bus.read_addr    = rd_ptr_q;
    assign bus.write_addr   = wr_ptr_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= AE_LIM);
    assign bus.almost_full  = (count_q >= AF_LIM);
    assign bus.read_value   = read_value_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_gen.sv
// Bench for fifo_ctrl_gen: RAM model plus a reference FIFO whose queue
// holds the data each accepted read must return.
module tb_fifo_ctrl_gen;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] wdata;
    logic [7:0] mem [16];

    fifo_ctrl_gen_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    fifo_ctrl_gen #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.front_value = mem[bus.read_addr];
    always @(posedge clk) if (bus.wr_en) mem[bus.write_addr] <= wdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] sbq [$];
    int         mcount;
    logic [3:0] mrp, mwp;
    logic [7:0] mrv;
    logic       mrvld, mov, mun;

    task automatic model_reset();
        sbq.delete();
        mcount = 0; mrp = '0; mwp = '0;
        mrv = 8'h00; mrvld = 1'b0; mov = 1'b0; mun = 1'b0;
    endtask

    task automatic idle();
        bus.read = 1'b0; bus.write = 1'b0;
        bus.flush = 1'b0; bus.clear_err = 1'b0;
        wdata = 8'h00;
    endtask

    // One clock: drive at the falling edge, predict, check after the rise.
    task automatic step(input logic r, input logic w, input logic [7:0] d,
                        input logic f, input logic c);
        logic er, ew, uf, of;
        logic [7:0] exp_v;
        bus.read = r; bus.write = w; bus.flush = f;
        bus.clear_err = c; wdata = d;
        #1;
        er = r && mcount != 0 && !f;
        ew = w && (mcount != 16 || er) && !f;
        uf = r && mcount == 0 && !f;
        of = w && mcount == 16 && !er && !f;
        n_chk++; if (bus.rd_en !== er) begin n_fail++; $display("FAIL rd_en: got %b want %b", bus.rd_en, er); end
        n_chk++; if (bus.wr_en !== ew) begin n_fail++; $display("FAIL wr_en: got %b want %b", bus.wr_en, ew); end
        exp_v = mrv;
        if (er) exp_v = sbq.pop_front();
        if (ew) sbq.push_back(d);
        if (f) begin
            mcount = 0; mrp = '0; mwp = '0; sbq.delete();
        end else begin
            mcount = mcount + int'(ew) - int'(er);
            if (er) mrp = mrp + 4'd1;
            if (ew) mwp = mwp + 4'd1;
        end
        if (er) mrv = exp_v;
        else if (uf) mrv = 8'h00;
        mrvld = er;
        if (c) begin mov = 1'b0; mun = 1'b0; end
        if (uf) mun = 1'b1;
        if (of) mov = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (bus.read_valid !== mrvld) begin n_fail++; $display("FAIL read_valid: got %b want %b", bus.read_valid, mrvld); end
        n_chk++; if (bus.read_value !== mrv) begin n_fail++; $display("FAIL read_value: got %h want %h", bus.read_value, mrv); end
        n_chk++; if (bus.count !== 5'(mcount)) begin n_fail++; $display("FAIL count: got %0d want %0d", bus.count, mcount); end
        n_chk++; if (bus.read_addr !== mrp) begin n_fail++; $display("FAIL read_addr: got %0d want %0d", bus.read_addr, mrp); end
        n_chk++; if (bus.write_addr !== mwp) begin n_fail++; $display("FAIL write_addr: got %0d want %0d", bus.write_addr, mwp); end
        n_chk++; if (bus.empty !== (mcount == 0)) begin n_fail++; $display("FAIL empty: got %b at count %0d", bus.empty, mcount); end
        n_chk++; if (bus.full !== (mcount == 16)) begin n_fail++; $display("FAIL full: got %b at count %0d", bus.full, mcount); end
        n_chk++; if (bus.almost_empty !== (mcount <= 2)) begin n_fail++; $display("FAIL almost_empty: got %b at count %0d", bus.almost_empty, mcount); end
        n_chk++; if (bus.almost_full !== (mcount >= 14)) begin n_fail++; $display("FAIL almost_full: got %b at count %0d", bus.almost_full, mcount); end
        n_chk++; if (bus.overflow !== mov) begin n_fail++; $display("FAIL overflow: got %b want %b", bus.overflow, mov); end
        n_chk++; if (bus.underflow !== mun) begin n_fail++; $display("FAIL underflow: got %b want %b", bus.underflow, mun); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        model_reset();
        #2;
        n_chk++; if (bus.count !== 5'd0 || bus.read_addr !== 4'd0 || bus.write_addr !== 4'd0) begin n_fail++; $display("FAIL reset_ptrs: got cnt=%0d ra=%0d wa=%0d want 0", bus.count, bus.read_addr, bus.write_addr); end
        n_chk++; if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got %b want 1010", {bus.empty, bus.full, bus.almost_empty, bus.almost_full}); end
        n_chk++; if (bus.read_value !== 8'h00 || bus.read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %h/%b want 00/0", bus.read_value, bus.read_valid); end
        n_chk++; if ({bus.overflow, bus.underflow, bus.rd_en, bus.wr_en} !== 4'b0000) begin n_fail++; $display("FAIL reset_err_en: got %b want 0000", {bus.overflow, bus.underflow, bus.rd_en, bus.wr_en}); end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h22, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        n_chk++; if (bus.count !== 5'd3 || bus.write_addr !== 4'd3 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL basic_fill: got cnt=%0d wa=%0d e=%b want 3/3/0", bus.count, bus.write_addr, bus.empty); end
        step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.read_value !== 8'h11) begin n_fail++; $display("FAIL basic_rd0: got %h want 11", bus.read_value); end
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.read_value !== 8'h33 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL basic_rd2: got %h e=%b want 33 e=1", bus.read_value, bus.empty); end
    endtask

    task automatic test_fill();
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        n_chk++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin n_fail++; $display("FAIL fill_full: got full=%b cnt=%0d want 1/16", bus.full, bus.count); end
        step(0, 1, 8'hEE, 0, 0);
        n_chk++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.write_addr !== 4'd0) begin n_fail++; $display("FAIL fill_over: got ov=%b cnt=%0d wa=%0d want 1/16/0", bus.overflow, bus.count, bus.write_addr); end
    endtask

    task automatic test_full_rw();
        step(1, 1, 8'hAA, 0, 0);
        n_chk++; if (bus.count !== 5'd16 || bus.read_addr !== 4'd1 || bus.write_addr !== 4'd1) begin n_fail++; $display("FAIL full_rw: got cnt=%0d ra=%0d wa=%0d want 16/1/1", bus.count, bus.read_addr, bus.write_addr); end
        for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.read_value !== 8'hAA) begin n_fail++; $display("FAIL full_drain_last: got %h want aa", bus.read_value); end
        step(0, 0, 8'h00, 0, 1);
    endtask

    task automatic test_empty();
        step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.underflow !== 1'b1 || bus.read_value !== 8'h00) begin n_fail++; $display("FAIL empty_rd: got un=%b rv=%h want 1/00", bus.underflow, bus.read_value); end
        step(1, 1, 8'h5C, 0, 0);
        n_chk++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL empty_rw: got cnt=%0d want 1", bus.count); end
        step(0, 1, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        n_chk++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_fail++; $display("FAIL clear_err: got ov=%b un=%b want 0/0", bus.overflow, bus.underflow); end
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.read_value !== 8'h00) begin n_fail++; $display("FAIL empty_order: got %h want 00", bus.read_value); end
    endtask

    task automatic test_wrap();
        step(0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 8'($urandom_range(0, 255)), 0, 0);
            step(1, 0, 8'h00, 0, 0);
        end
        n_chk++; if (bus.read_addr !== 4'd8 || bus.write_addr !== 4'd8) begin n_fail++; $display("FAIL wrap_ptrs: got ra=%0d wa=%0d want 8/8", bus.read_addr, bus.write_addr); end
    endtask

    task automatic test_flush_reset();
        logic [7:0] held;
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
        step(1, 0, 8'h00, 0, 0);
        held = bus.read_value;
        n_chk++; if (bus.count !== 5'd7 || held !== 8'hC0) begin n_fail++; $display("FAIL pre_flush: got cnt=%0d rv=%h want 7/c0", bus.count, held); end
        step(1, 1, 8'h99, 1, 0);
        n_chk++; if (bus.read_value !== held || bus.read_valid !== 1'b0 || bus.count !== 5'd0) begin n_fail++; $display("FAIL flush: got rv=%h vld=%b cnt=%0d want %h/0/0", bus.read_value, bus.read_valid, bus.count, held); end
        step(0, 1, 8'h01, 0, 0);
        step(0, 1, 8'h02, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        bus.write = 1'b1; wdata = 8'h03;
        #2 reset = 1'b0;
        #1;
        n_chk++; if (bus.count !== 5'd0 || bus.read_addr !== 4'd0 || bus.write_addr !== 4'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ptrs: got cnt=%0d ra=%0d wa=%0d e=%b", bus.count, bus.read_addr, bus.write_addr, bus.empty); end
        n_chk++; if (bus.read_value !== 8'h00 || bus.read_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_read: got %h/%b want 00/0", bus.read_value, bus.read_valid); end
        idle();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 8'h77, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        n_chk++; if (bus.read_value !== 8'h77) begin n_fail++; $display("FAIL after_reset: got %h want 77", bus.read_value); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_fill();
        test_full_rw();
        test_empty();
        test_wrap();
        test_flush_reset();
        n_chk++; if (sbq.size() != 0 && mcount == 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", sbq.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end want finish");
        $fatal(1, "timeout");
    end
endmodule
